prescaled_counter_bank: RTL and testbench
=========================================

Name: prescaled_counter_bank

Overview:
- Parametrised bank of N independent event counters sharing one enable/select input.
- Each channel has a programmable prescaler, so a channel counts every (Div+1)-th selected event.
- Each channel wraps or saturates on overflow and keeps a sticky overflow flag.
- Generalises the two-channel fixed 1:1 / 1:4 counter. Sits under the debug/statistics register block.

Parameters:
- N, 2, number of counter channels (1..16).
- WIDTH, 64, bits per counter.
- DIV_W, 4, prescaler divider width; divide ratio = Div+1 (1..2^DIV_W).
- SEL_W, 1, width of Sel / Cfg_Ch; must satisfy 2^SEL_W >= N.
- DEFAULT_DIV, 0, reset value of every channel's Div register.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- En  in  1  event strobe, one event per cycle when high.
- Sel  in  SEL_W  channel receiving the event.
- Clr  in  1  synchronous clear of all counts, prescalers and Ovf flags.
- Cfg_We  in  1  configuration write strobe.
- Cfg_Ch  in  SEL_W  channel targeted by the configuration write.
- Cfg_Div  in  DIV_W  new divider value.
- Cfg_Sat  in  1  new mode: 1 = saturate, 0 = wrap.
- Count  out  N*WIDTH  registered counts; channel i occupies bits [i*WIDTH +: WIDTH].
- Ovf  out  N  sticky per-channel overflow flags.
- Ovf_Any  out  1  OR of Ovf, registered with Ovf.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - Count = 0, Ovf = 0, Ovf_Any = 0, all prescalers = 0.
  - Div[i] = DEFAULT_DIV, Sat[i] = 0.
  - Reset takes effect immediately on assertion, including mid-count and mid-config.
- Event on channel i: En = 1, Sel = i, i < N, and no Cfg_We to channel i in the same cycle.
  - Sel >= N: event ignored, no state change.
  - If pre[i] == Div[i]: pre[i] <= 0 and Count[i] steps.
  - Otherwise: pre[i] <= pre[i] + 1 and Count[i] is held.
  - Div = 0 counts every event. Div = 3 counts every 4th event (legacy mode).
- Count step:
  - Count[i] < 2^WIDTH-1: increment by 1.
  - Count[i] at max, wrap mode: Count[i] <= 0, Ovf[i] <= 1.
  - Count[i] at max, saturate mode: Count[i] held at max, Ovf[i] <= 1.
- Ovf[i] is sticky. Only Reset_n or Clr clears it.
- Latency: Count, Ovf and Ovf_Any update on the edge that samples the event; visible 1 cycle after the strobe.
- Config write (Cfg_We = 1, Cfg_Ch = c < N):
  - Div[c] <= Cfg_Div, Sat[c] <= Cfg_Sat, pre[c] <= 0.
  - Count[c] and Ovf[c] are unchanged.
  - An event to channel c in the same cycle is dropped.
  - Cfg_Ch >= N: write ignored.
- Clr priority:
  - Clr beats events and config writes in the same cycle.
  - Clears Count, pre and Ovf on all channels. Div and Sat are retained.
  - A Cfg_We in the Clr cycle is discarded.
- Divider shrink:
  - Writing a smaller Div always zeroes pre, so pre > Div never occurs.
  - Implementation still compares with ">=", for robustness.
- Single event per cycle: at most one channel changes per cycle, excluding Clr and reset.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, N=2, WIDTH=4, Div=0: 5 events on ch0 -> Count0 = 5, Count1 = 0, Ovf = 00, each count visible 1 cycle after its strobe.
- Cfg ch1 Div = 3, then 9 events on ch1 -> Count1 = 2 after the 8th event, unchanged after the 9th, pre1 = 1.
- WIDTH=4 wrap: 17 events on ch0 with Div=0 -> Count0 = 0 on the 16th event, Ovf0 = 1, Ovf_Any = 1, Count0 = 1 after the 17th event.
- Saturate: set ch0 Sat=1, then 20 events -> Count0 holds 15, Ovf0 = 1. Clr -> Count0 = 0, Ovf = 00, Sat still 1.
- Same-cycle collisions:
  - Clr with an event on ch1 -> Count1 = 0.
  - Cfg_We ch1 with an event on ch1 -> event dropped, Count1 unchanged, pre1 = 0.
  - Sel = 2 with N = 2 -> no change.
- Async reset: Reset_n pulsed low between clock edges during counting -> all outputs 0 before the next edge; Div restored to DEFAULT_DIV.

Source files
------------

// File: rtl/prescaled_counter_bank_if.sv
// Event, configuration and result signals of the prescaled counter bank.
interface prescaled_counter_bank_if #(
   parameter int unsigned N     = 2,
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIV_W = 4,
   parameter int unsigned SEL_W = 1
);
   logic               En;
   logic [SEL_W-1:0]   Sel;
   logic               Clr;
   logic               Cfg_We;
   logic [SEL_W-1:0]   Cfg_Ch;
   logic [DIV_W-1:0]   Cfg_Div;
   logic               Cfg_Sat;
   logic [N*WIDTH-1:0] Count;
   logic [N-1:0]       Ovf;
   logic               Ovf_Any;

   modport master (
      output En, Sel, Clr, Cfg_We, Cfg_Ch, Cfg_Div, Cfg_Sat,
      input  Count, Ovf, Ovf_Any
   );

   modport slave (
      input  En, Sel, Clr, Cfg_We, Cfg_Ch, Cfg_Div, Cfg_Sat,
      output Count, Ovf, Ovf_Any
   );
endinterface

// File: rtl/prescaled_counter_bank.sv
// Bank of N event counters with per-channel prescaler, wrap/saturate mode and
// sticky overflow. The bus interface must be built with the same parameters.
module prescaled_counter_bank #(
   parameter int unsigned N           = 2,
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned DIV_W       = 4,
   parameter int unsigned SEL_W       = 1,
   parameter int unsigned DEFAULT_DIV = 0
) (
   input logic                      Clk,
   input logic                      Reset_n,
   prescaled_counter_bank_if.slave  bus
);
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] cnt_q [N];
   logic [WIDTH-1:0] cnt_d [N];
   logic [DIV_W-1:0] pre_q [N];
   logic [DIV_W-1:0] pre_d [N];
   logic [DIV_W-1:0] div_q [N];
   logic [DIV_W-1:0] div_d [N];
   logic [N-1:0]     sat_q, sat_d;
   logic [N-1:0]     ovf_q, ovf_d;
   logic             ovf_any_q, ovf_any_d;

   // Next-state: Clr over config over event; config to a channel drops its event.
   always_comb begin
      sat_d = sat_q;
      ovf_d = ovf_q;
      for (int unsigned i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         pre_d[i] = pre_q[i];
         div_d[i] = div_q[i];
         if (bus.Clr) begin
            cnt_d[i] = '0;
            pre_d[i] = '0;
            ovf_d[i] = 1'b0;
         end else if (bus.Cfg_We && (bus.Cfg_Ch == SEL_W'(i))) begin
            div_d[i] = bus.Cfg_Div;
            sat_d[i] = bus.Cfg_Sat;
            pre_d[i] = '0;
         end else if (bus.En && (bus.Sel == SEL_W'(i))) begin
            if (pre_q[i] >= div_q[i]) begin
               pre_d[i] = '0;
               if (cnt_q[i] != CNT_MAX) begin
                  cnt_d[i] = cnt_q[i] + WIDTH'(1);
               end else begin
                  ovf_d[i] = 1'b1;
                  cnt_d[i] = sat_q[i] ? CNT_MAX : '0;
               end
            end else begin
               pre_d[i] = pre_q[i] + DIV_W'(1);
            end
         end
      end
      ovf_any_d = |ovf_d;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
            pre_q[i] <= '0;
            div_q[i] <= DIV_W'(DEFAULT_DIV);
         end
         sat_q     <= '0;
         ovf_q     <= '0;
         ovf_any_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
            pre_q[i] <= pre_d[i];
            div_q[i] <= div_d[i];
         end
         sat_q     <= sat_d;
         ovf_q     <= ovf_d;
         ovf_any_q <= ovf_any_d;
      end
   end

   for (genvar g = 0; g < int'(N); g++) begin : g_count
      assign bus.Count[g*WIDTH +: WIDTH] = cnt_q[g];
   end
   assign bus.Ovf     = ovf_q;
   assign bus.Ovf_Any = ovf_any_q;
endmodule

// File: tb/tb_prescaled_counter_bank.sv
// Randomised and directed checks of prescaled_counter_bank against a behavioural model.
module tb_prescaled_counter_bank;
   localparam int N = 2;
   localparam int WIDTH = 4;
   localparam int MAXV = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   prescaled_counter_bank_if #(.N(2), .WIDTH(4), .DIV_W(4), .SEL_W(2)) bus ();

   prescaled_counter_bank #(.N(2), .WIDTH(4), .DIV_W(4), .SEL_W(2), .DEFAULT_DIV(0)) dut (
      .Clk(clk), .Reset_n(rst_n), .bus(bus)
   );

   // Model: events seen since the last counted one, and the counts as integers.
   int m_cnt [N];
   int m_seen [N];
   int m_div [N];
   bit m_sat [N];
   bit m_ovf [N];

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0; m_seen[i] = 0; m_div[i] = 0; m_sat[i] = 0; m_ovf[i] = 0;
      end
   endfunction

   function automatic logic [7:0] exp_count();
      logic [3:0] c0, c1;
      c0 = 4'(m_cnt[0]);
      c1 = 4'(m_cnt[1]);
      return {c1, c0};
   endfunction

   function automatic logic [1:0] exp_ovf();
      return {m_ovf[1], m_ovf[0]};
   endfunction

   task automatic step(input logic en, input int sel, input logic clr, input logic we,
                       input int ch, input int div, input logic sat);
      bus.En = en; bus.Sel = 2'(sel); bus.Clr = clr;
      bus.Cfg_We = we; bus.Cfg_Ch = 2'(ch); bus.Cfg_Div = 4'(div); bus.Cfg_Sat = sat;
      @(posedge clk);
      if (clr) begin
         for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_seen[i] = 0; m_ovf[i] = 0; end
      end else begin
         if (we && ch < N) begin
            m_div[ch] = div; m_sat[ch] = sat; m_seen[ch] = 0;
         end
         if (en && sel < N && !(we && ch == sel)) begin
            m_seen[sel]++;
            if (m_seen[sel] == m_div[sel] + 1) begin
               m_seen[sel] = 0;
               if (m_cnt[sel] == MAXV) begin
                  m_ovf[sel] = 1;
                  m_cnt[sel] = m_sat[sel] ? MAXV : 0;
               end else m_cnt[sel]++;
            end
         end
      end
      #1;
      bus.En = 0; bus.Clr = 0; bus.Cfg_We = 0;
   endtask

   task automatic test_reset();
      bus.En = 0; bus.Sel = 0; bus.Clr = 0; bus.Cfg_We = 0; bus.Cfg_Ch = 0;
      bus.Cfg_Div = 0; bus.Cfg_Sat = 0;
      model_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.Count !== 8'h00 || bus.Ovf !== 2'b00 || bus.Ovf_Any !== 1'b0) begin
         errors++;
         $display("FAIL reset: Count=%h Ovf=%b Any=%b, required 00 00 0", bus.Count, bus.Ovf, bus.Ovf_Any);
      end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      for (int k = 1; k <= 5; k++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         checks++;
         if (bus.Count !== {4'd0, 4'(k)} || bus.Ovf !== 2'b00) begin
            errors++;
            $display("FAIL basic[%0d]: Count=%h Ovf=%b, required %h 00", k, bus.Count, bus.Ovf, {4'd0, 4'(k)});
         end
      end
   endtask

   task automatic test_prescale();
      step(0, 0, 0, 1, 1, 3, 0);
      for (int k = 1; k <= 9; k++) begin
         step(1, 1, 0, 0, 0, 0, 0);
         checks++;
         if (bus.Count !== exp_count()) begin
            errors++;
            $display("FAIL prescale[%0d]: Count=%h, required %h", k, bus.Count, exp_count());
         end
      end
      checks++;
      if (bus.Count[7:4] !== 4'd2) begin
         errors++;
         $display("FAIL prescale_9: Count1=%0d, required 2", bus.Count[7:4]);
      end
      // Residual prescale of 1 means three more events reach the next count.
      repeat (3) step(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (bus.Count[7:4] !== 4'd3) begin
         errors++;
         $display("FAIL prescale_residue: Count1=%0d, required 3", bus.Count[7:4]);
      end
   endtask

   task automatic test_wrap();
      step(0, 0, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 17; k++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         checks++;
         if (bus.Count[3:0] !== 4'(k) || bus.Ovf[0] !== (k >= 16) || bus.Ovf_Any !== (k >= 16)) begin
            errors++;
            $display("FAIL wrap[%0d]: Count0=%0d Ovf0=%b Any=%b, required %0d %0d", k,
                     bus.Count[3:0], bus.Ovf[0], bus.Ovf_Any, 4'(k), k >= 16);
         end
      end
   endtask

   task automatic test_saturate();
      step(0, 0, 0, 1, 0, 0, 1);
      repeat (20) step(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.Count[3:0] !== 4'd15 || bus.Ovf[0] !== 1'b1) begin
         errors++;
         $display("FAIL saturate: Count0=%0d Ovf0=%b, required 15 1", bus.Count[3:0], bus.Ovf[0]);
      end
      step(0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (bus.Count !== 8'h00 || bus.Ovf !== 2'b00 || bus.Ovf_Any !== 1'b0) begin
         errors++;
         $display("FAIL sat_clr: Count=%h Ovf=%b Any=%b, required 00 00 0", bus.Count, bus.Ovf, bus.Ovf_Any);
      end
      repeat (17) step(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.Count[3:0] !== 4'd15) begin
         errors++;
         $display("FAIL sat_kept: Count0=%0d, required 15", bus.Count[3:0]);
      end
   endtask

   task automatic test_collisions();
      step(0, 0, 0, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      checks++;
      if (bus.Count[7:4] !== 4'd0) begin
         errors++;
         $display("FAIL clr_event: Count1=%0d, required 0", bus.Count[7:4]);
      end
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 1, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (bus.Count[7:4] !== 4'd1) begin
         errors++;
         $display("FAIL clr_drops_cfg: Count1=%0d, required 1", bus.Count[7:4]);
      end
      step(1, 1, 0, 1, 1, 1, 0);
      checks++;
      if (bus.Count[7:4] !== 4'd1) begin
         errors++;
         $display("FAIL cfg_event: Count1=%0d, required 1", bus.Count[7:4]);
      end
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (bus.Count[7:4] !== 4'd2) begin
         errors++;
         $display("FAIL cfg_pre_zero: Count1=%0d, required 2", bus.Count[7:4]);
      end
      step(1, 2, 0, 1, 3, 5, 1);
      checks++;
      if (bus.Count !== exp_count() || bus.Ovf !== exp_ovf()) begin
         errors++;
         $display("FAIL sel_oob: Count=%h Ovf=%b, required %h %b", bus.Count, bus.Ovf, exp_count(), exp_ovf());
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         checks++;
         if (bus.Count !== exp_count() || bus.Ovf !== exp_ovf() || bus.Ovf_Any !== (|exp_ovf())) begin
            errors++;
            $display("FAIL random[%0d]: Count=%h Ovf=%b Any=%b, required %h %b %b", k,
                     bus.Count, bus.Ovf, bus.Ovf_Any, exp_count(), exp_ovf(), |exp_ovf());
         end
      end
   endtask

   task automatic test_async_reset();
      step(0, 0, 0, 1, 1, 5, 1);
      repeat (4) step(1, 0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      checks++;
      if (bus.Count !== 8'h00 || bus.Ovf !== 2'b00 || bus.Ovf_Any !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: Count=%h Ovf=%b Any=%b, required 00 00 0", bus.Count, bus.Ovf, bus.Ovf_Any);
      end
      #1;
      rst_n = 1;
      step(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (bus.Count[7:4] !== 4'd1) begin
         errors++;
         $display("FAIL default_div: Count1=%0d, required 1", bus.Count[7:4]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prescale();
      test_wrap();
      test_saturate();
      test_collisions();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
